// File: rtl/dmac_req_arb.sv
// Upstream request arbiter and per-channel transfer-length counter for the
// DMA controller. Picks one requesting channel by round-robin, launches the
// controller with a one-cycle start, counts completed beats and reports
// terminal count, abort or a rejected configuration write.
module dmac_req_arb #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_ch,
  input  logic [CW-1:0]            cfg_len,
  input  logic                     beat,
  output logic [NCH-1:0]           grant,
  output logic [$clog2(NCH)-1:0]   ch_id,
  output logic                     start,
  output logic                     busy,
  output logic [CW-1:0]            cnt,
  output logic                     tc,
  output logic                     abort,
  output logic                     cfg_err
);

  localparam int unsigned CHW = $clog2(NCH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CHW-1:0]   ptr;
  logic [CW-1:0]    len     [NCH];
  logic [CW-1:0]    len_nxt [NCH];

  logic [NCH-1:0]   elig;
  logic             win_vld;
  logic [CHW-1:0]   win_idx;
  logic [CHW-1:0]   srch_idx;
  logic             cfg_hit_act;
  logic             cfg_ok;
  logic             dec_now;
  logic             len_zero;

  // A channel may be granted only while it requests and has beats left
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      elig[i] = req[i] && (len[i] != '0);
    end
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    srch_idx = '0;
    for (int j = 1; j <= NCH; j++) begin
      srch_idx = CHW'((32'(ptr) + 32'(j)) % NCH);
      if (!win_vld && elig[srch_idx]) begin
        win_vld = 1'b1;
        win_idx = srch_idx;
      end
    end
  end

  // Config writes to the active channel are refused; out-of-range indices are dropped silently
  always_comb begin
    cfg_hit_act = cfg_we && busy && (cfg_ch == ch_id);
    cfg_ok      = cfg_we && (32'(cfg_ch) < NCH) && !cfg_hit_act;
    dec_now     = (state == S_XFER) && beat;
  end

  // Next value of every length register: config load or saturating beat decrement
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      len_nxt[i] = len[i];
    end
    if (cfg_ok) begin
      len_nxt[cfg_ch] = cfg_len;
    end
    if (dec_now && (len[ch_id] != '0)) begin
      len_nxt[ch_id] = len[ch_id] - CW'(1);
    end
    len_zero = (len_nxt[ch_id] == '0);
  end

  // Per-channel length storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        len[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        len[i] <= len_nxt[i];
      end
    end
  end

  // Transfer FSM with registered grant, status and pulse outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ptr     <= CHW'(NCH - 1);
      grant   <= '0;
      ch_id   <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      tc      <= 1'b0;
      abort   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      start   <= 1'b0;
      tc      <= 1'b0;
      abort   <= 1'b0;
      cfg_err <= cfg_hit_act;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            grant <= NCH'(1) << win_idx;
            ch_id <= win_idx;
            busy  <= 1'b1;
            start <= 1'b1;
            cnt   <= len_nxt[win_idx];
            state <= S_ARM;
          end
        end
        S_ARM: begin
          // beat is not counted while the controller is being launched
          cnt   <= len_nxt[ch_id];
          state <= S_XFER;
        end
        S_XFER: begin
          cnt <= len_nxt[ch_id];
          if (dec_now && len_zero) begin
            tc    <= 1'b1;
            state <= S_DONE;
          end else if (!req[ch_id]) begin
            abort <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          ptr   <= ch_id;
          grant <= '0;
          ch_id <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_req_arb.sv
// Scoreboard bench for dmac_req_arb: expected start/end/cfg_err events are
// queued as stimulus is applied and retired by a negedge monitor.
module tb_dmac_req_arb;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned CHW = $clog2(NCH);

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] req;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_len;
  logic           beat;
  logic [NCH-1:0] grant;
  logic [CHW-1:0] ch_id;
  logic           start;
  logic           busy;
  logic [CW-1:0]  cnt;
  logic           tc;
  logic           abort;
  logic           cfg_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // expected grant per start; end code (tc:0x20|ch, abort:0x10|ch); cfg_err ch_id
  int unsigned q_start[$];
  int unsigned q_end[$];
  int unsigned q_err[$];

  dmac_req_arb #(.NCH(NCH), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_len (cfg_len),
    .beat    (beat),
    .grant   (grant),
    .ch_id   (ch_id),
    .start   (start),
    .busy    (busy),
    .cnt     (cnt),
    .tc      (tc),
    .abort   (abort),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int len);
    cfg_we  = 1'b1;
    cfg_ch  = CHW'(ch);
    cfg_len = CW'(len);
    step(1);
    cfg_we  = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n;
    n = 0;
    step(1);
    while (!start && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(start), 1);
  endtask

  task automatic wait_grant(input string tag, input logic [NCH-1:0] g, input int budget);
    int n;
    n = 0;
    step(1);
    while (grant !== g && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(grant), 32'(g));
  endtask

  function automatic int unsigned all_outs();
    return 32'({grant, ch_id, start, busy, cnt, tc, abort, cfg_err});
  endfunction

  // Retire queued expectations whenever the DUT pulses an event
  always @(negedge clk) begin
    if (start) begin
      if (q_start.size() == 0) chk("start_unexpected", 32'(start), 0);
      else                     chk("start_grant", 32'(grant), q_start.pop_front());
    end
    if (tc || abort) begin
      if (q_end.size() == 0) chk("end_unexpected", 32'({tc, abort}), 0);
      else                   chk("end_event", (32'({tc, abort}) << 4) | 32'(ch_id), q_end.pop_front());
    end
    if (cfg_err) begin
      if (q_err.size() == 0) chk("cfg_err_unexpected", 32'(cfg_err), 0);
      else                   chk("cfg_err_ch", 32'(ch_id), q_err.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_len = '0; beat = 1'b0;
    step(2);
    chk("rst_outs", all_outs(), 0);
    rst = 1'b1;
    step(1);
    chk("idle_outs", all_outs(), 0);

    // basic transfer of 3 beats on ch0, beat during ARM ignored
    cfg(0, 3);
    q_start.push_back(32'h1);
    req = 4'b0001;
    wait_start("s1_start", 6);
    chk("s1_busy_arm", 32'(busy), 1);
    chk("s1_cnt_arm", 32'(cnt), 3);
    beat = 1'b1;
    step(1);
    chk("s1_arm_beat_ignored", 32'(cnt), 3);
    chk("s1_start_one_cycle", 32'(start), 0);
    step(1);
    chk("s1_cnt2", 32'(cnt), 2);
    step(1);
    chk("s1_cnt1", 32'(cnt), 1);
    q_end.push_back(32'h20);
    step(1);
    chk("s1_cnt0_done", 32'(cnt), 0);
    chk("s1_busy_done", 32'(busy), 1);
    beat = 1'b0;
    step(1);
    chk("s1_busy_drop", 32'(busy), 0);
    chk("s1_grant_clr", 32'(grant), 0);
    step(3);
    chk("s1_len0_no_regrant", 32'(busy), 0);
    req = '0;

    // round-robin order from reset, with wrap back to ch0
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) cfg(i, 1);
    q_start.push_back(32'h1); q_start.push_back(32'h2); q_start.push_back(32'h4);
    q_start.push_back(32'h8); q_start.push_back(32'h1);
    q_end.push_back(32'h20); q_end.push_back(32'h21); q_end.push_back(32'h22);
    q_end.push_back(32'h23); q_end.push_back(32'h20);
    beat = 1'b1;
    req  = 4'hF;
    wait_grant("s2_grant_ch1", 4'b0010, 20);
    cfg(0, 1);
    step(25);
    req  = '0;
    beat = 1'b0;
    chk("s2_starts_seen", q_start.size(), 0);
    chk("s2_tcs_seen", q_end.size(), 0);

    // abort after two beats, remaining count kept for next grant
    cfg(2, 5);
    q_start.push_back(32'h4);
    req = 4'b0100;
    wait_start("s3_start", 6);
    chk("s3_cnt_arm", 32'(cnt), 5);
    beat = 1'b1;
    step(1);
    chk("s3_cnt5", 32'(cnt), 5);
    step(1);
    chk("s3_cnt4", 32'(cnt), 4);
    step(1);
    chk("s3_cnt3", 32'(cnt), 3);
    beat = 1'b0;
    req  = '0;
    q_end.push_back(32'h12);
    step(1);
    chk("s3_cnt_abort", 32'(cnt), 3);
    step(2);
    chk("s3_idle", 32'(busy), 0);
    q_start.push_back(32'h4);
    req = 4'b0100;
    wait_start("s3_restart", 6);
    chk("s3_len_retained", 32'(cnt), 3);
    req = '0;
    q_end.push_back(32'h12);
    step(4);
    chk("s3_end_seen", q_end.size(), 0);

    // rejected write to active ch1, accepted write to ch3
    cfg(1, 4);
    q_start.push_back(32'h2);
    req = 4'b0010;
    wait_start("s4_start", 6);
    step(1);
    cfg_we = 1'b1; cfg_ch = CHW'(1); cfg_len = CW'(9);
    q_err.push_back(32'h1);
    step(1);
    cfg_ch = CHW'(3); cfg_len = CW'(2);
    step(1);
    cfg_we = 1'b0;
    chk("s4_cnt_kept", 32'(cnt), 4);
    chk("s4_no_err_ch3", 32'(cfg_err), 0);
    beat = 1'b1;
    q_end.push_back(32'h21);
    step(2);
    chk("s4_cnt2", 32'(cnt), 2);
    step(2);
    chk("s4_busy_done", 32'(busy), 1);
    beat = 1'b0;
    req  = '0;
    step(1);
    chk("s4_busy_drop", 32'(busy), 0);
    q_start.push_back(32'h8);
    req = 4'b1000;
    wait_start("s4_ch3_start", 6);
    chk("s4_ch3_len", 32'(cnt), 2);
    req = '0;
    q_end.push_back(32'h13);
    step(4);

    // zero-length channel never granted; async reset mid-transfer
    req = 4'b0010;
    step(5);
    chk("s5_len0_idle", 32'(busy), 0);
    req = '0;
    cfg(0, 5);
    q_start.push_back(32'h1);
    req = 4'b0001;
    wait_start("s5_start", 6);
    beat = 1'b1;
    step(2);
    chk("s5_cnt4", 32'(cnt), 4);
    #2;
    rst = 1'b0;
    #1;
    chk("s5_async_rst", all_outs(), 0);
    step(3);
    rst  = 1'b1;
    beat = 1'b0;
    step(4);
    chk("s5_len_cleared", 32'(busy), 0);
    req = '0;
    step(2);

    chk("q_start_empty", q_start.size(), 0);
    chk("q_end_empty", q_end.size(), 0);
    chk("q_err_empty", q_err.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
